// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT constants, mode encoding and modular add/sub helpers
package ntt_pkg;

    localparam int W = 23;
    localparam int Q = 8380417;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (W+1)'(Q)) begin
            s = s - (W+1)'(Q);
        end
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        if (a < b) begin
            d = {1'b0, a} + (W+1)'(Q) - {1'b0, b};
        end else begin
            d = {1'b0, a} - {1'b0, b};
        end
        return d[W-1:0];
    endfunction

endpackage

// File: rtl/mod_mul_pipe.sv
// rtl/mod_mul_pipe.sv - pipelined modular multiplier, z = a*b mod Q after MUL_STAGES enabled cycles
module mod_mul_pipe #(
    parameter int W          = 23,
    parameter int Q          = 8380417,
    parameter int MUL_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] z
);

    // Barrett constants sized to the bit length of Q so the quotient estimate is off by at most 2
    localparam int             K  = $clog2(Q);
    localparam logic [2*K:0]   R2 = {1'b1, {(2*K){1'b0}}};
    localparam logic [K:0]     MU = (K+1)'(R2 / (2*K+1)'(Q));

    logic [2*W-1:0] prod_q;
    logic [K:0]     t;
    logic [2*K+1:0] tm;
    logic [K:0]     qh;
    logic [2*K+1:0] qq;
    logic [K+1:0]   r;
    logic [W-1:0]   red;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else if (en) begin
            prod_q <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
    end

    always_comb begin
        t  = (K+1)'(prod_q >> (K-1));
        tm = (2*K+2)'(t) * (2*K+2)'(MU);
        qh = tm[2*K+1:K+1];
        qq = (2*K+2)'(qh) * (2*K+2)'(Q);
        r  = prod_q[K+1:0] - qq[K+1:0];
        if (r >= (K+2)'(Q)) begin
            r = r - (K+2)'(Q);
        end
        if (r >= (K+2)'(Q)) begin
            r = r - (K+2)'(Q);
        end
        red = W'(r);
    end

    generate
        if (MUL_STAGES == 1) begin : g_one
            assign z = red;
        end else begin : g_multi
            logic [W-1:0] dly_q [MUL_STAGES-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MUL_STAGES-1; i++) begin
                        dly_q[i] <= '0;
                    end
                end else if (en) begin
                    dly_q[0] <= red;
                    for (int i = 1; i < MUL_STAGES-1; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign z = dly_q[MUL_STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/bu_pipe.sv
// rtl/bu_pipe.sv - pipelined CT/GS radix-2 butterfly with valid/ready and sideband tag
module bu_pipe #(
    parameter int W          = ntt_pkg::W,
    parameter int Q          = ntt_pkg::Q,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [W-1:0]     in_tf,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    output logic [TAG_W-1:0] out_tag
);

    import ntt_pkg::*;

    localparam int LAST = MUL_STAGES - 1;

    logic             advance;
    logic             s1_vld_q, s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [W-1:0]     s1_u_q, s1_v_q, s1_tf_q, s1_u_d, s1_v_d;
    logic             m_vld_q  [MUL_STAGES];
    logic             m_mode_q [MUL_STAGES];
    logic [TAG_W-1:0] m_tag_q  [MUL_STAGES];
    logic [W-1:0]     m_u_q    [MUL_STAGES];
    logic [W-1:0]     prod;
    logic             s2_vld_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [W-1:0]     s2_a_q, s2_b_q, s2_a_d, s2_b_d;

    assign advance  = !s2_vld_q || out_ready;
    assign in_ready = advance;

    // u carries X (CT) or the sum (GS) past the multiplier; v is the multiplicand
    always_comb begin
        s1_u_d = in_x;
        s1_v_d = in_y;
        if (in_mode == MODE_GS) begin
            s1_u_d = mod_add(in_x, in_y);
            s1_v_d = mod_sub(in_x, in_y);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_mode_q <= MODE_CT;
            s1_tag_q  <= '0;
            s1_u_q    <= '0;
            s1_v_q    <= '0;
            s1_tf_q   <= '0;
        end else if (advance) begin
            s1_vld_q  <= in_valid;
            s1_mode_q <= in_mode;
            s1_tag_q  <= in_tag;
            s1_u_q    <= s1_u_d;
            s1_v_q    <= s1_v_d;
            s1_tf_q   <= in_tf;
        end
    end

    mod_mul_pipe #(.W(W), .Q(Q), .MUL_STAGES(MUL_STAGES)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .a     (s1_v_q),
        .b     (s1_tf_q),
        .z     (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                m_vld_q[i]  <= 1'b0;
                m_mode_q[i] <= MODE_CT;
                m_tag_q[i]  <= '0;
                m_u_q[i]    <= '0;
            end
        end else if (advance) begin
            m_vld_q[0]  <= s1_vld_q;
            m_mode_q[0] <= s1_mode_q;
            m_tag_q[0]  <= s1_tag_q;
            m_u_q[0]    <= s1_u_q;
            for (int i = 1; i < MUL_STAGES; i++) begin
                m_vld_q[i]  <= m_vld_q[i-1];
                m_mode_q[i] <= m_mode_q[i-1];
                m_tag_q[i]  <= m_tag_q[i-1];
                m_u_q[i]    <= m_u_q[i-1];
            end
        end
    end

    always_comb begin
        s2_a_d = m_u_q[LAST];
        s2_b_d = prod;
        if (m_mode_q[LAST] == MODE_CT) begin
            s2_a_d = mod_add(m_u_q[LAST], prod);
            s2_b_d = mod_sub(m_u_q[LAST], prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_tag_q <= '0;
            s2_a_q   <= '0;
            s2_b_q   <= '0;
        end else if (advance) begin
            s2_vld_q <= m_vld_q[LAST];
            s2_tag_q <= m_tag_q[LAST];
            s2_a_q   <= s2_a_d;
            s2_b_q   <= s2_b_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_a     = s2_a_q;
    assign out_b     = s2_b_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_bu_pipe.sv
// tb/tb_bu_pipe.sv - self-checking bench for bu_pipe: vector table, backpressure, reset, random stream
module tb_bu_pipe;

    localparam int     W     = 23;
    localparam longint Q     = 8380417;
    localparam int     TAG_W = 8;
    localparam int     LAT   = 4;
    localparam int     N_RND = 10000;

    logic             clk, rst_n;
    logic             in_valid, in_ready, in_mode;
    logic [W-1:0]     in_x, in_y, in_tf;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready;
    logic [W-1:0]     out_a, out_b;
    logic [TAG_W-1:0] out_tag;

    bu_pipe #(.W(W), .Q(8380417), .MUL_STAGES(2), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tf     (in_tf),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic   mode;
        longint x, y, tf;
        longint ea, eb;
    } vec_t;

    typedef struct {
        longint a, b;
        int     tag;
    } exp_t;

    int     checks = 0;
    int     errors = 0;
    int     n_out  = 0;
    logic   in_fired;
    logic   hold_pend;
    longint hold_a, hold_b, hold_tag;
    exp_t   exp_q [$];
    vec_t   vecs [8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_bu(input logic mode, input longint x, input longint y, input longint tf,
                                   output longint a, output longint b);
        longint p;
        if (mode == 1'b0) begin
            p = (tf * y) % Q;
            a = (x + p) % Q;
            b = (x - p + Q) % Q;
        end else begin
            a = (x + y) % Q;
            b = (((x - y + Q) % Q) * tf) % Q;
        end
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge
    task automatic cycle();
        exp_t e;
        #1;
        in_fired = in_valid && in_ready;
        if (hold_pend && out_valid) begin
            chk("hold_a", longint'(out_a), hold_a);
            chk("hold_b", longint'(out_b), hold_b);
            chk("hold_tag", longint'(out_tag), hold_tag);
        end
        hold_pend = out_valid && !out_ready;
        hold_a    = longint'(out_a);
        hold_b    = longint'(out_b);
        hold_tag  = longint'(out_tag);
        if (out_valid && out_ready) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_result: got tag %0d expected no result", out_tag);
            end else begin
                e = exp_q.pop_front();
                chk("res_a", longint'(out_a), e.a);
                chk("res_b", longint'(out_b), e.b);
                chk("res_tag", longint'(out_tag), longint'(e.tag));
            end
        end
        if (in_fired) begin
            ref_bu(in_mode, longint'(in_x), longint'(in_y), longint'(in_tf), e.a, e.b);
            e.tag = int'(in_tag);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic mode, input longint x, input longint y, input longint tf, input int tag);
        in_mode = mode;
        in_x    = W'(x);
        in_y    = W'(y);
        in_tf   = W'(tf);
        in_tag  = TAG_W'(tag);
    endtask

    task automatic single_latency(input string name, input vec_t v, input int tag);
        int lat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(v.mode, v.x, v.y, v.tf, tag);
        cycle();
        chk({name, "_accept"}, longint'(in_fired), 1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        chk({name, "_latency"}, longint'(lat), longint'(LAT));
        chk({name, "_a"}, longint'(out_a), v.ea);
        chk({name, "_b"}, longint'(out_b), v.eb);
        chk({name, "_tag"}, longint'(out_tag), longint'(tag));
        cycle();
    endtask

    initial begin
        int idx, base, c, sent;
        vec_t v;

        vecs[0] = '{1'b0, 5, 3, 2, 11, Q-1};
        vecs[1] = '{1'b1, 5, 3, 2, 8, 4};
        vecs[2] = '{1'b0, Q-1, 1, 1, 0, Q-2};
        vecs[3] = '{1'b1, 0, 1, 1, 1, Q-1};
        vecs[4] = '{1'b1, Q-1, Q-1, Q-1, Q-2, 0};
        vecs[5] = '{1'b0, 0, 0, 12345, 0, 0};
        vecs[6] = '{1'b0, 100, Q-1, Q-1, 101, 99};
        vecs[7] = '{1'b1, 7, 9, 3, 16, Q-6};

        hold_pend = 1'b0;
        in_fired  = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_a", longint'(out_a), 0);
        chk("rst_out_b", longint'(out_b), 0);
        chk("rst_out_tag", longint'(out_tag), 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            single_latency($sformatf("vec%0d", i), vecs[i], i + 16);
        end

        // Backpressure: six back-to-back inputs against a stalled consumer
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            drive(1'(idx), 1000 + idx, 77 * idx, 3 + idx, idx);
            cycle();
            if (in_fired) idx++;
        end
        chk("bp_accepted", longint'(idx), 4);
        chk("bp_in_ready", longint'(in_ready), 0);
        chk("bp_out_valid", longint'(out_valid), 1);
        base = n_out;
        out_ready = 1'b1;
        c = 0;
        while ((idx < 6 || exp_q.size() > 0) && c < 40) begin
            in_valid = (idx < 6);
            drive(1'(idx), 1000 + idx, 77 * idx, 3 + idx, idx);
            cycle();
            if (in_fired) idx++;
            c++;
        end
        in_valid = 1'b0;
        chk("bp_delivered", longint'(n_out - base), 6);

        // Reset with a full pipe must discard everything in flight
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            drive(1'b0, 5, 3, 2, 200 + k);
            cycle();
        end
        in_valid = 1'b0;
        chk("mid_pre_valid", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_a", longint'(out_a), 0);
        chk("mid_rst_b", longint'(out_b), 0);
        chk("mid_rst_tag", longint'(out_tag), 0);
        exp_q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        base = n_out;
        for (int k = 0; k < 6; k++) begin
            cycle();
        end
        chk("mid_no_stale", longint'(n_out - base), 0);
        single_latency("post_rst", vecs[1], 42);

        // Random mixed-mode stream with random valid/ready
        sent = 0;
        c = 0;
        while ((sent < N_RND || exp_q.size() > 0) && c < 60000) begin
            in_valid  = (sent < N_RND) && ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            case ($urandom_range(7, 0))
                0:       drive(1'($urandom_range(1, 0)), Q-1, Q-1, $urandom_range(8380416, 0), sent);
                1:       drive(1'($urandom_range(1, 0)), 0, $urandom_range(8380416, 0), Q-1, sent);
                default: drive(1'($urandom_range(1, 0)), $urandom_range(8380416, 0),
                               $urandom_range(8380416, 0), $urandom_range(8380416, 0), sent);
            endcase
            cycle();
            if (in_fired) sent++;
            c++;
        end
        in_valid = 1'b0;
        chk("rnd_sent", longint'(sent), longint'(N_RND));
        chk("rnd_drained", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
